// File: rtl/ipsxe_floating_point_chunk_carry_split_v1_0_if.sv
// Handshake/operand bus for the chunk-serial A - B + C engine.
// The slice stream signals exist only with IPSXE_FLT_CHUNK_SLICE_STREAM_EN defined.
interface ipsxe_floating_point_chunk_carry_split_v1_0_if #(
    parameter int WIDTH = 54,
    parameter int CHUNK = 18
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] i_c;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic [1:0]       o_carry;
    logic             o_busy;
`ifdef IPSXE_FLT_CHUNK_SLICE_STREAM_EN
    logic             o_slice_valid;
    logic [CHUNK-1:0] o_slice_sum;
    logic [1:0]       o_slice_carry;
    logic [IDXW-1:0]  o_slice_idx;
`endif

    modport slave (
        input  i_valid, i_a, i_b, i_c, i_ready,
        output o_ready, o_valid, o_sum, o_carry, o_busy
`ifdef IPSXE_FLT_CHUNK_SLICE_STREAM_EN
        , output o_slice_valid, o_slice_sum, o_slice_carry, o_slice_idx
`endif
    );

    modport master (
        output i_valid, i_a, i_b, i_c, i_ready,
        input  o_ready, o_valid, o_sum, o_carry, o_busy
`ifdef IPSXE_FLT_CHUNK_SLICE_STREAM_EN
        , input o_slice_valid, o_slice_sum, o_slice_carry, o_slice_idx
`endif
    );
endinterface

// File: rtl/ipsxe_floating_point_chunk_carry_split_v1_0.sv
// Chunk-serial signed A - B + C with a 2-bit signed group carry per slice.
// Optional per-slice output stream: define IPSXE_FLT_CHUNK_SLICE_STREAM_EN.
module ipsxe_floating_point_chunk_carry_split_v1_0 #(
    parameter int WIDTH = 54,
    parameter int CHUNK = 18
) (
    input  logic i_clk,
    input  logic i_rst_n,
    ipsxe_floating_point_chunk_carry_split_v1_0_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [1:0]       carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [CHUNK+1:0] s;
    logic [WIDTH-1:0] sum_shift;

    // Operands shift right one slice per RUN cycle, so the active slice is
    // always the low CHUNK bits; results shift in from the top.
    always_comb begin
        s = {2'b00, a_q[CHUNK-1:0]} - {2'b00, b_q[CHUNK-1:0]}
          + {2'b00, c_q[CHUNK-1:0]} + {{CHUNK{carry_q[1]}}, carry_q};
    end

    generate
        if (NCHUNK == 1) begin : g_one
            assign sum_shift = s[CHUNK-1:0];
        end else begin : g_multi
            assign sum_shift = {s[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid && ready_q) begin
                    state_d = RUN;
                    a_d     = bus.i_a;
                    b_d     = bus.i_b;
                    c_d     = bus.i_c;
                    carry_d = '0;
                    idx_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                c_d     = c_q >> CHUNK;
                sum_d   = sum_shift;
                carry_d = s[CHUNK+1:CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDXW'(NCHUNK - 1)) state_d = DONE;
            end
            DONE: begin
                if (valid_q && bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // o_valid lags DONE entry by one register stage and drops on handoff
        valid_d = (state_q == DONE) && (state_d == DONE);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_carry = carry_q;
    assign bus.o_busy  = busy_q;

`ifdef IPSXE_FLT_CHUNK_SLICE_STREAM_EN
    logic             slice_valid_q, slice_valid_d;
    logic [CHUNK-1:0] slice_sum_q, slice_sum_d;
    logic [1:0]       slice_carry_q, slice_carry_d;
    logic [IDXW-1:0]  slice_idx_q, slice_idx_d;

    always_comb begin
        slice_valid_d = (state_q == RUN);
        slice_sum_d   = slice_sum_q;
        slice_carry_d = slice_carry_q;
        slice_idx_d   = slice_idx_q;
        if (state_q == RUN) begin
            slice_sum_d   = s[CHUNK-1:0];
            slice_carry_d = s[CHUNK+1:CHUNK];
            slice_idx_d   = idx_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slice_valid_q <= 1'b0;
            slice_sum_q   <= '0;
            slice_carry_q <= '0;
            slice_idx_q   <= '0;
        end else begin
            slice_valid_q <= slice_valid_d;
            slice_sum_q   <= slice_sum_d;
            slice_carry_q <= slice_carry_d;
            slice_idx_q   <= slice_idx_d;
        end
    end

    assign bus.o_slice_valid = slice_valid_q;
    assign bus.o_slice_sum   = slice_sum_q;
    assign bus.o_slice_carry = slice_carry_q;
    assign bus.o_slice_idx   = slice_idx_q;
`endif
endmodule

// File: tb/tb_ipsxe_floating_point_chunk_carry_split_v1_0.sv
// Directed self-checking bench for the chunk-serial A - B + C engine (WIDTH=54, CHUNK=18).
module tb_ipsxe_floating_point_chunk_carry_split_v1_0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ipsxe_floating_point_chunk_carry_split_v1_0_if #(.WIDTH(54), .CHUNK(18)) bus ();

    ipsxe_floating_point_chunk_carry_split_v1_0 #(.WIDTH(54), .CHUNK(18)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one operand set, measure accept->o_valid latency, check the result
    // and, with i_ready high, the handoff back to IDLE.
    task automatic run_op(input string tag, input logic [53:0] a, input logic [53:0] b,
                          input logic [53:0] c, input logic [53:0] exp_sum,
                          input logic [1:0] exp_carry);
        int lat;
        check({tag, "_ready_before"}, 64'(bus.o_ready), 64'd1);
        bus.i_a = a;
        bus.i_b = b;
        bus.i_c = c;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check({tag, "_busy_run"}, 64'(bus.o_busy), 64'd1);
        check({tag, "_ready_run"}, 64'(bus.o_ready), 64'd0);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (bus.o_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(bus.o_sum), 64'(exp_sum));
        check({tag, "_carry"}, 64'(bus.o_carry), 64'(exp_carry));
        if (bus.i_ready) begin
            @(posedge clk); #1;
            check({tag, "_valid_drop"}, 64'(bus.o_valid), 64'd0);
            check({tag, "_ready_back"}, 64'(bus.o_ready), 64'd1);
        end
    endtask

`ifdef IPSXE_FLT_CHUNK_SLICE_STREAM_EN
    bit mon_en  = 1'b0;
    int mon_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (mon_en && bus.o_slice_valid) begin
            check("slice_idx", 64'(bus.o_slice_idx), 64'(mon_cnt));
            check("slice_sum", 64'(bus.o_slice_sum), 64'h3FFFF);
            check("slice_carry", 64'(bus.o_slice_carry), 64'd3);
            mon_cnt++;
        end
    end
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_c = '0;
        #12;
        check("rst_ready", 64'(bus.o_ready), 64'd1);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_sum", 64'(bus.o_sum), 64'd0);
        check("rst_carry", 64'(bus.o_carry), 64'd0);
        check("rst_busy", 64'(bus.o_busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1", 54'd1, 54'd0, 54'd0, 54'd1, 2'b00);
        run_op("t2", 54'h3FFFF, 54'd0, 54'd1, 54'h40000, 2'b00);
`ifdef IPSXE_FLT_CHUNK_SLICE_STREAM_EN
        mon_en = 1'b1;
`endif
        run_op("t3", 54'd0, 54'd1, 54'd0, 54'h3F_FFFF_FFFF_FFFF, 2'b11);
`ifdef IPSXE_FLT_CHUNK_SLICE_STREAM_EN
        mon_en = 1'b0;
        check("t3_slice_count", 64'(mon_cnt), 64'd3);
`endif
        run_op("t4", 54'h3F_FFFF_FFFF_FFFF, 54'd0, 54'h3F_FFFF_FFFF_FFFF,
               54'h3F_FFFF_FFFF_FFFE, 2'b01);

        // Backpressure in DONE with new operands offered
        bus.i_ready = 1'b0;
        bus.i_a = 54'd5;
        bus.i_b = 54'd2;
        bus.i_c = 54'd10;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        got = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (bus.o_valid) begin
                got = n;
                break;
            end
        end
        check("t5_latency", 64'(got), 64'd4);
        for (int n = 0; n < 5; n++) begin
            bus.i_a = 54'h2A_AAAA_AAAA_AAAA;
            bus.i_b = 54'd7;
            bus.i_c = 54'(n);
            bus.i_valid = 1'b1;
            @(posedge clk); #1;
            check("t5_hold_valid", 64'(bus.o_valid), 64'd1);
            check("t5_hold_sum", 64'(bus.o_sum), 64'd13);
            check("t5_hold_carry", 64'(bus.o_carry), 64'd0);
            check("t5_hold_ready", 64'(bus.o_ready), 64'd0);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_valid_drop", 64'(bus.o_valid), 64'd0);
        check("t5_ready_back", 64'(bus.o_ready), 64'd1);
        check("t5_sum_retained", 64'(bus.o_sum), 64'd13);

        // Asynchronous reset while slice 1 is being computed
        bus.i_a = 54'h3F_FFFF_FFFF_FFFF;
        bus.i_b = 54'd3;
        bus.i_c = 54'h12345;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(bus.o_valid), 64'd0);
        check("t6_rst_sum", 64'(bus.o_sum), 64'd0);
        check("t6_rst_carry", 64'(bus.o_carry), 64'd0);
        check("t6_rst_busy", 64'(bus.o_busy), 64'd0);
        check("t6_rst_ready", 64'(bus.o_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("t6_after", 54'h1234_5678_9ABC, 54'h0000_FFFF_0000, 54'd1,
               54'h1233_5679_9ABD, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
